led_flow: RTL and testbench
===========================

// Module: led_flow
// PURPOSE
//  Board-level running-light driver: one lit LED steps across a 4-bit LED bank at a fixed rate
//  derived from the system clock (default 50 MHz clock, 0.5 s per step). Sits at top level,
//  driving the LED pins directly; no handshake or host interface.
// PARAMETERS
//  N_LED        4           number of LEDs / width of led bus (>=2)
//  STEP_CYCLES  25_000_000  clock cycles per pattern step (>=2); 0.5 s at 50 MHz
//  ACTIVE_LOW   0           1: led bus inverted at output (0 = lit); internal pattern unchanged
// PORTS
//  clk    input   1      system clock, 50 MHz nominal, all logic on rising edge
//  rst    input   1      synchronous reset, active-high (sampled on clk rising edge)
//  led    output  N_LED  LED drive pattern (bit i lit = 1 when ACTIVE_LOW=0)
// BEHAVIOUR
//  - One clock domain, one synchronous active-high reset; no asynchronous logic.
//  - Reset (rst=1 at a clk edge): prescaler cnt <= 0, pattern <= 'b0...01, dir <= DIR_UP;
//    led = 4'b0001 (4'b1110 if ACTIVE_LOW). Reset asserted mid-step discards partial count.
//  - Prescaler: cnt width $clog2(STEP_CYCLES); counts 0..STEP_CYCLES-1, then wraps to 0.
//    tick = (cnt == STEP_CYCLES-1), combinational, high exactly one cycle per period.
//  - Pattern advances on the edge where tick=1; first change occurs on the STEP_CYCLES-th
//    rising edge after the first edge sampling rst=0. Exactly one bit set at all times.
//  - Default (wrap) sequence: rotate left 0001->0010->0100->1000->0001 (MSB wraps to LSB).
//  - led is registered-pattern driven (no glitches); polarity applied by ACTIVE_LOW only.
//  - rst and tick in same cycle: reset wins.
//  - Pattern register is self-correcting: if not one-hot (e.g. upset), next tick loads 'b0..01.
// CONFIGURATION
//  LED_FLOW_BOUNCE_EN
//   defined: ping-pong sequence 0001->0010->0100->1000->0100->0010->0001->...; dir register
//     flips to DIR_DOWN when stepping into MSB and to DIR_UP when stepping into LSB;
//     ends are visited once per sweep (period 2*(N_LED-1) steps).
//   undefined: wrap rotation as above; dir register absent (or constant DIR_UP).
// STRUCTURE
//  - Package led_flow_pkg: typedef enum logic {DIR_UP, DIR_DOWN} led_dir_t;
//    localparams DEF_STEP_CYCLES=25_000_000, DEF_N_LED=4, PATTERN_RST='b1.
//  - Sub-module led_flow_tick (params STEP_CYCLES; ports clk, rst, tick): prescaler only.
//  - Top led_flow: instantiates led_flow_tick, holds pattern/dir registers, output polarity.
// TESTING (bench uses STEP_CYCLES=4, N_LED=4, 20 ns clock)
//  1. rst=1 for 200 cycles -> led==4'b0001 throughout, cnt==0, no change.
//  2. Release rst -> led stays 0001 for edges 1..3, becomes 0010 on edge 4, 0100 on edge 8,
//     1000 on edge 12, 0001 on edge 16 (wrap build).
//  3. Assert rst for 1 cycle mid-step (cnt==2, led==0100) -> led==0001 next edge, and next
//     change exactly 4 edges after rst drops.
//  4. Run 1000 cycles -> $onehot(led) every cycle; change only when tick was high.
//  5. LED_FLOW_BOUNCE_EN build -> sequence 0001,0010,0100,1000,0100,0010,0001,0010 at 4-edge spacing.
//  6. ACTIVE_LOW=1 -> after reset led==4'b1110; after 4 edges 4'b1101.

Source files
------------

// File: rtl/led_flow_pkg.sv
// Shared types and defaults for the running-light driver.
// The optional ping-pong sequence is selected by the LED_FLOW_BOUNCE_EN macro in led_flow.
package led_flow_pkg;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } led_dir_t;

  localparam int          DEF_STEP_CYCLES = 25_000_000;
  localparam int          DEF_N_LED       = 4;
  localparam int unsigned PATTERN_RST     = 'b1;

endpackage

// File: rtl/led_flow_tick.sv
// Step-rate prescaler: counts 0..STEP_CYCLES-1 and raises tick for the last count of each period.
module led_flow_tick
  import led_flow_pkg::*;
#(
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_flow.sv
// Running-light driver: one lit LED steps across the bank once per prescaler period.
// Define LED_FLOW_BOUNCE_EN for a ping-pong sweep; otherwise the light rotates and wraps.
module led_flow
  import led_flow_pkg::*;
#(
  parameter int N_LED       = DEF_N_LED,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [N_LED-1:0] led
);

  localparam logic [N_LED-1:0] PAT_RST = N_LED'(PATTERN_RST);

  logic             tick;
  logic [N_LED-1:0] pattern;
  logic             pattern_ok;

  led_flow_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // A corrupted (zero or multi-hot) pattern is reloaded on the next step.
  assign pattern_ok = (pattern != '0) && ((pattern & (pattern - N_LED'(1))) == '0);

`ifdef LED_FLOW_BOUNCE_EN
  led_dir_t dir;
  logic     step_up;

  // Never shift off an end, even if dir disagrees with where the light is.
  assign step_up = (dir == DIR_UP) ? !pattern[N_LED-1] : pattern[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= PAT_RST;
      dir     <= DIR_UP;
    end else if (tick) begin
      if (!pattern_ok) begin
        pattern <= PAT_RST;
        dir     <= DIR_UP;
      end else if (step_up) begin
        pattern <= pattern << 1;
        dir     <= pattern[N_LED-2] ? DIR_DOWN : DIR_UP;
      end else begin
        pattern <= pattern >> 1;
        dir     <= pattern[1] ? DIR_UP : DIR_DOWN;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= PAT_RST;
    end else if (tick) begin
      if (!pattern_ok) begin
        pattern <= PAT_RST;
      end else begin
        pattern <= {pattern[N_LED-2:0], pattern[N_LED-1]};
      end
    end
  end
`endif

  assign led = ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: tb/tb_led_flow.sv
// Bench for led_flow with STEP_CYCLES=4, N_LED=4; a second instance covers ACTIVE_LOW=1.
module tb_led_flow;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] led;
  logic [3:0] led_n;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] m_pat;
  logic       m_down;

  // ---------------- clock / DUTs ----------------
  always #10 clk = ~clk;

  led_flow #(
    .N_LED(4), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .led (led)
  );

  led_flow #(
    .N_LED(4), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk (clk),
    .rst (rst),
    .led (led_n)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pat  = 4'b0001;
    m_down = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
`ifdef LED_FLOW_BOUNCE_EN
    if (!m_down) begin
      m_pat = m_pat << 1;
      if (m_pat[3]) m_down = 1'b1;
    end else begin
      m_pat = m_pat >> 1;
      if (m_pat[0]) m_down = 1'b0;
    end
`else
    m_pat = {m_pat[2:0], m_pat[3]};
`endif
  endtask

  // ---------------- driver ----------------
  // Holds rst for n edges; returns at a falling edge with rst low, so the next rising edge is edge 1.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0001) begin
        errors++;
        $display("FAIL reset_led cycle %0d got %b want 0001", i, led);
      end
      checks++;
      if (led_n !== 4'b1110) begin
        errors++;
        $display("FAIL reset_led_n cycle %0d got %b want 1110", i, led_n);
      end
    end
    checks++;
    if (dut.u_tick.cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", dut.u_tick.cnt);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequence();
    logic [3:0] held;
    for (int s = 0; s < 8; s++) begin
      model_step();
      exp_q.push_back(m_pat);
    end
    held = 4'b0001;
    for (int e = 1; e <= 8 * STEP; e++) begin
      @(negedge clk);
      if (e % STEP == 0) held = exp_q.pop_front();
      checks++;
      if (led !== held) begin
        errors++;
        $display("FAIL seq_led edge %0d got %b want %b", e, led, held);
      end
      checks++;
      if (led_n !== ~held) begin
        errors++;
        $display("FAIL seq_led_n edge %0d got %b want %b", e, led_n, ~held);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] held;
    apply_reset(2);
    for (int s = 0; s < 2; s++) begin
      model_step();
      exp_q.push_back(m_pat);
    end
    held = 4'b0001;
    for (int e = 1; e <= 2 * STEP + 2; e++) begin
      @(negedge clk);
      if (e % STEP == 0) held = exp_q.pop_front();
      checks++;
      if (led !== held) begin
        errors++;
        $display("FAIL mid_pre edge %0d got %b want %b", e, led, held);
      end
    end
    checks++;
    if (led !== 4'b0100 || dut.u_tick.cnt !== 2'd2) begin
      errors++;
      $display("FAIL mid_setup got led %b cnt %0d want led 0100 cnt 2", led, dut.u_tick.cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || dut.u_tick.cnt !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst got led %b cnt %0d want led 0001 cnt 0", led, dut.u_tick.cnt);
    end
    rst = 1'b0;
    model_reset();
    model_step();
    exp_q.push_back(m_pat);
    held = 4'b0001;
    for (int e = 1; e <= STEP; e++) begin
      @(negedge clk);
      if (e == STEP) held = exp_q.pop_front();
      checks++;
      if (led !== held) begin
        errors++;
        $display("FAIL mid_post edge %0d got %b want %b", e, led, held);
      end
    end
  endtask

  task automatic test_long_run();
    logic [3:0] held;
    logic [3:0] prev;
    apply_reset(3);
    for (int s = 0; s < 1000 / STEP; s++) begin
      model_step();
      exp_q.push_back(m_pat);
    end
    held = 4'b0001;
    prev = 4'b0001;
    for (int e = 1; e <= 1000; e++) begin
      @(negedge clk);
      if (e % STEP == 0) held = exp_q.pop_front();
      checks++;
      if (!$onehot(led)) begin
        errors++;
        $display("FAIL long_onehot edge %0d got %b want one-hot", e, led);
      end
      checks++;
      if (led !== prev && (e % STEP) != 0) begin
        errors++;
        $display("FAIL long_untimed_change edge %0d got %b want %b", e, led, prev);
      end
      checks++;
      if (led !== held) begin
        errors++;
        $display("FAIL long_led edge %0d got %b want %b", e, led, held);
      end
      prev = led;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_queue got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_active_low();
    apply_reset(1);
    checks++;
    if (led_n !== 4'b1110) begin
      errors++;
      $display("FAIL al_reset got %b want 1110", led_n);
    end
    model_step();
    exp_q.push_back(~m_pat);
    repeat (STEP) @(negedge clk);
    checks++;
    if (led_n !== exp_q[0]) begin
      errors++;
      $display("FAIL al_step got %b want %b", led_n, exp_q[0]);
    end
    checks++;
    if (led_n !== 4'b1101) begin
      errors++;
      $display("FAIL al_step_const got %b want 1101", led_n);
    end
    void'(exp_q.pop_front());
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_sequence();
    test_mid_reset();
    test_long_run();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
